// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational lookup, MEM-stage training.
// Optional BTB_STATS_EN adds hit/mispredict statistics counters and their ports.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            bp_hit,
   output logic            bp_taken,
   output logic [XLEN-1:0] bp_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            inv
`ifdef BTB_STATS_EN
  ,output logic [31:0]     stat_lookups,
   output logic [31:0]     stat_mispred
`endif
);

   localparam int TAG_W = XLEN - 2 - IDX_W;

   logic [ENTRIES-1:0]             valid_q;
   logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
   logic [ENTRIES-1:0][XLEN-1:0]  tgt_q;
   logic [ENTRIES-1:0][1:0]       ctr_q;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit, up_pred;

   logic             wr_en;
   logic [1:0]       ctr_d;
   logic [XLEN-1:0]  tgt_d;

   // Address bits below the word offset never take part in indexing or tagging.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

   assign lk_idx = if_pc[IDX_W+1:2];
   assign lk_tag = if_pc[XLEN-1:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[XLEN-1:IDX_W+2];

   assign bp_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign bp_taken  = bp_hit && ctr_q[lk_idx][1];
   assign bp_target = bp_hit ? tgt_q[lk_idx] : '0;

   assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_pred = up_hit && ctr_q[up_idx][1];

   always_comb begin
      wr_en = 1'b0;
      ctr_d = ctr_q[up_idx];
      tgt_d = tgt_q[up_idx];
      if (upd_valid && !inv) begin
         if (up_hit) begin
            wr_en = 1'b1;
            if (upd_taken) begin
               ctr_d = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
               tgt_d = upd_target;
            end else begin
               ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            // Allocation evicts whatever lives at this index, starting weakly taken.
            wr_en = 1'b1;
            ctr_d = 2'b10;
            tgt_d = upd_target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         tag_q   <= '0;
         tgt_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      end else if (inv) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[up_idx] <= 1'b1;
         tag_q[up_idx]   <= up_tag;
         tgt_q[up_idx]   <= tgt_d;
         ctr_q[up_idx]   <= ctr_d;
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] lookups_q, mispred_q;
   logic        mispred;

   // A taken prediction with a stale target is as costly as a wrong direction.
   assign mispred = upd_valid &&
                    ((up_pred != upd_taken) ||
                     (up_pred && upd_taken && (tgt_q[up_idx] != upd_target)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lookups_q <= '0;
         mispred_q <= '0;
      end else begin
         if (bp_hit)  lookups_q <= lookups_q + 32'd1;
         if (mispred) mispred_q <= mispred_q + 32'd1;
      end
   end

   assign stat_lookups = lookups_q;
   assign stat_mispred = mispred_q;
`endif

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the fetch stage's PC-select mux. Each cycle it looks up the current fetch PC combinationally and supplies the fetch stage with three values: hit, predicted direction, and predicted target. It is trained one cycle later by the resolved branch outcome from the MEM stage. The fetch stage turns these values into its taken/not-taken select and hit indications; the MEM stage's mispredict logic consumes the same prediction carried down the pipe.

## Interface
Parameters:
- ENTRIES, 16, number of table entries; power of two, 4..256.
- IDX_W, 4, log2(ENTRIES); must match ENTRIES.
- XLEN, 32, address width.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  fetch PC being looked up this cycle.
- bp_hit  out  1  valid entry with matching tag for if_pc.
- bp_taken  out  1  prediction is taken: bp_hit AND counter[1].
- bp_target  out  XLEN  stored target when bp_hit, else 0.
- upd_valid  in  1  a resolved branch/jump is in MEM this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target address.
- inv  in  1  clear every valid bit (fence.i / debug).
- stat_lookups  out  32  only with BTB_STATS_EN; count of cycles where bp_hit=1.
- stat_mispred  out  32  only with BTB_STATS_EN; count of resolved updates whose outcome disagreed with the prediction.

## Operation
- Entry fields: valid, tag, target[XLEN-1:0], ctr[1:0].
- Tag width is XLEN-2-IDX_W.
- Index is pc[IDX_W+1:2]; tag is pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup is purely combinational from if_pc and the registered table.
- Update, applied on the clock edge when upd_valid=1:
  - Hit on upd_pc, upd_taken=1: ctr saturates up (11 stays 11); target overwritten with upd_target.
  - Hit on upd_pc, upd_taken=0: ctr saturates down (00 stays 00). The entry stays valid and the target is unchanged.
  - Miss, upd_taken=1: allocate, overwriting whatever entry is at that index. Sets valid=1, tag, target=upd_target, ctr=10 (weakly taken).
  - Miss, upd_taken=0: no change.
- Invalidation: inv=1 clears all valid bits at the edge. Tags, targets and counters are left as they are.
- inv and upd_valid in the same cycle: inv wins and the update is dropped.
- Mispredict for statistics:
  - The predicted direction is recomputed from the table state at upd_pc in the update cycle: hit AND ctr[1].
  - A mispredict is counted when that predicted direction differs from upd_taken, or when the prediction is taken, upd_taken=1, and the stored target differs from upd_target.

## Timing
- Lookup latency: 0 cycles.
- Update latency: 1 cycle. A write at edge N is visible to a lookup in the cycle after edge N.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no write-to-read bypass.
- Reset (rst=0, asynchronous):
  - All valid bits=0, all ctr=01, all targets and tags=0.
  - Therefore bp_hit=0, bp_taken=0, bp_target=0.
  - stat_lookups=0 and stat_mispred=0.
- Reset mid-update: the table still clears; a pending update is lost.
- Statistics counters wrap from 0xFFFFFFFF to 0.

## Configuration
- BTB_STATS_EN defined: stat_lookups and stat_mispred ports and their counters exist and behave as described above.
- BTB_STATS_EN undefined:
  - The ports and counters are removed.
  - No other behaviour changes; prediction outputs are identical cycle for cycle.

## Test plan
- Reset then lookup: rst low then high, if_pc=0x0000_0040 -> bp_hit=0, bp_taken=0, bp_target=0.
- Allocate and hit:
  - Stimulus: upd_valid=1, upd_pc=0x40, upd_taken=1, upd_target=0x100. Next cycle if_pc=0x40.
  - Required: bp_hit=1, bp_taken=1, bp_target=0x100.
  - Required: if_pc=0x80 (same index at ENTRIES=16, different tag) -> bp_hit=0.
- Counter saturation:
  - Stimulus: from ctr=10, three not-taken updates to 0x40.
  - Required: ctr goes 01 then 00 then stays 00; bp_taken=0 and bp_hit=1 throughout.
  - Stimulus: then two taken updates.
  - Required: ctr=10 and bp_taken=1.
- Same-cycle collision:
  - Stimulus: lookup if_pc=0x40 in the same cycle as the allocating update for 0x40.
  - Required: bp_hit=0 that cycle, bp_hit=1 the next cycle.
- Invalidate priority:
  - Stimulus: with entry 0x40 valid, assert inv=1 and upd_valid=1 (upd_pc=0x44, taken) together.
  - Required: next cycle both 0x40 and 0x44 miss.
- Stats (BTB_STATS_EN defined):
  - Stimulus: 5 hit cycles, and 2 updates whose outcome disagrees with the prediction.
  - Required: stat_lookups=5 and stat_mispred=2.
  - Required: rebuilt without the macro, the prediction outputs match on the same stimulus.
